// File: rtl/nano_dsi_pkg.sv
// Shared definitions for the nano DSI D-PHY transmit front end:
// LP line encodings, the HS sync byte, lane state types and the
// phase-length helper used to load the phase timers.
package nano_dsi_pkg;

    // LP line pair encodings, packed as {lp_p, lp_n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // Leader byte sent before the packet payload
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        CLK_IDLE  = 3'd0,
        CLK_LPX   = 3'd1,
        CLK_PREP  = 3'd2,
        CLK_ZERO  = 3'd3,
        CLK_RUN   = 3'd4,
        CLK_TRAIL = 3'd5,
        CLK_EXIT  = 3'd6
    } clk_state_e;

    typedef enum logic [3:0] {
        DAT_IDLE    = 4'd0,
        DAT_LPX     = 4'd1,
        DAT_PREP    = 4'd2,
        DAT_ZERO    = 4'd3,
        DAT_ALIGN   = 4'd4,
        DAT_SYNC    = 4'd5,
        DAT_PAYLOAD = 4'd6,
        DAT_TRAIL   = 4'd7,
        DAT_EXIT    = 4'd8
    } dat_state_e;

    // Timer load value for a phase of cfg cycles; a zero setting behaves as one cycle
    function automatic logic [7:0] phase_load(input logic [7:0] cfg);
        phase_load = (cfg == 8'd0) ? 8'd0 : (cfg - 8'd1);
    endfunction

endpackage

// File: rtl/nano_dsi_clk.sv
// Clock lane of the D-PHY transmitter: LP entry sequence, free-running HS
// clock with a byte-boundary strobe, and HS exit. Defining
// NANO_DSI_CLK_CONT_EN keeps the lane in RUN once reached (continuous clock).
module nano_dsi_clk import nano_dsi_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_lpx_i,
    input  logic [7:0] cfg_hs_prep_i,
    input  logic [7:0] cfg_hs_zero_i,
    input  logic [7:0] cfg_hs_trail_i,
    input  logic       hs_clk_req_i,
    output logic       hs_clk_rdy_o,
    output logic       clk_sync_o,
    output logic       lp_p_o,
    output logic       lp_n_o,
    output logic       hs_p_o,
    output logic       hs_n_o
);

    clk_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tog_q, tog_d;
    logic       stop_q, stop_d;
    logic [1:0] lp_q, lp_d;
    logic       hs_p_q, hs_p_d;
    logic       hs_n_q, hs_n_d;
    logic       rdy_q, rdy_d;
    logic       sync_q, sync_d;
    logic       tmr_load_s;
    logic [7:0] tmr_val_s;
    logic       tmr_done_s;

    nano_dsi_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .done_o     (tmr_done_s)
    );

    // Lane sequencing, RUN bit counter and HS clock toggle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tog_d      = tog_q;
        stop_d     = stop_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = 8'd0;
        case (state_q)
            CLK_IDLE: begin
                if (hs_clk_req_i) begin
                    state_d    = CLK_LPX;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_lpx_i);
                end else begin
                    state_d = CLK_IDLE;
                end
            end
            CLK_LPX: begin
                if (tmr_done_s) begin
                    state_d    = CLK_PREP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_hs_prep_i);
                end else begin
                    state_d = CLK_LPX;
                end
            end
            CLK_PREP: begin
                if (tmr_done_s) begin
                    state_d    = CLK_ZERO;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_hs_zero_i);
                end else begin
                    state_d = CLK_PREP;
                end
            end
            CLK_ZERO: begin
                if (tmr_done_s) begin
                    state_d   = CLK_RUN;
                    bit_cnt_d = 3'd0;
                    tog_d     = 1'b1;
                    stop_d    = 1'b0;
                end else begin
                    state_d = CLK_ZERO;
                end
            end
            CLK_RUN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                tog_d     = ~tog_q;
`ifdef NANO_DSI_CLK_CONT_EN
                // Continuous clock: the request is not looked at again
                state_d = CLK_RUN;
                stop_d  = 1'b0;
`else
                // A drop of the request, however short, is remembered until the byte ends
                if ((bit_cnt_q == 3'd7) && (stop_q || !hs_clk_req_i)) begin
                    state_d    = CLK_TRAIL;
                    stop_d     = 1'b0;
                    tog_d      = 1'b0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_hs_trail_i);
                end else if (!hs_clk_req_i) begin
                    stop_d = 1'b1;
                end else begin
                    stop_d = stop_q;
                end
`endif
            end
            CLK_TRAIL: begin
                if (tmr_done_s) begin
                    state_d    = CLK_EXIT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_lpx_i);
                end else begin
                    state_d = CLK_TRAIL;
                end
            end
            CLK_EXIT: begin
                if (tmr_done_s) begin
                    state_d = CLK_IDLE;
                end else begin
                    state_d = CLK_EXIT;
                end
            end
            default: begin
                state_d = CLK_IDLE;
            end
        endcase
    end

    // Pin and flag values for the state being entered, so outputs are registered
    always_comb begin
        lp_d   = LP11;
        hs_p_d = 1'b0;
        hs_n_d = 1'b0;
        case (state_d)
            CLK_IDLE, CLK_EXIT: begin
                lp_d = LP11;
            end
            CLK_LPX: begin
                lp_d = LP01;
            end
            CLK_PREP: begin
                lp_d = LP00;
            end
            CLK_ZERO, CLK_TRAIL: begin
                lp_d   = LP00;
                hs_n_d = 1'b1;
            end
            CLK_RUN: begin
                lp_d   = LP00;
                hs_p_d = tog_d;
                hs_n_d = ~tog_d;
            end
            default: begin
                lp_d = LP11;
            end
        endcase
        rdy_d  = (state_d == CLK_RUN);
        sync_d = (state_d == CLK_RUN) && (bit_cnt_d == 3'd7);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLK_IDLE;
            bit_cnt_q <= 3'd0;
            tog_q     <= 1'b0;
            stop_q    <= 1'b0;
            lp_q      <= LP11;
            hs_p_q    <= 1'b0;
            hs_n_q    <= 1'b0;
            rdy_q     <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tog_q     <= tog_d;
            stop_q    <= stop_d;
            lp_q      <= lp_d;
            hs_p_q    <= hs_p_d;
            hs_n_q    <= hs_n_d;
            rdy_q     <= rdy_d;
            sync_q    <= sync_d;
        end
    end

    assign lp_p_o       = lp_q[1];
    assign lp_n_o       = lp_q[0];
    assign hs_p_o       = hs_p_q;
    assign hs_n_o       = hs_n_q;
    assign hs_clk_rdy_o = rdy_q;
    assign clk_sync_o   = sync_q;

endmodule

// File: rtl/nano_dsi_data.sv
// Data lane of the D-PHY transmitter: waits for a byte boundary, runs the
// LP/HS entry sequence, sends the sync byte and payload LSB-first aligned to
// the clock lane strobe, then trails with the inverse of the last bit.
module nano_dsi_data import nano_dsi_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_lpx_i,
    input  logic [7:0] cfg_hs_prep_i,
    input  logic [7:0] cfg_hs_zero_i,
    input  logic [7:0] cfg_hs_trail_i,
    input  logic       clk_sync_i,
    input  logic       hs_start_i,
    input  logic [7:0] hs_data_i,
    input  logic       hs_last_i,
    output logic       hs_ack_o,
    output logic       lp_p_o,
    output logic       lp_n_o,
    output logic       hs_p_o,
    output logic       hs_n_o
);

    dat_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       last_q, last_d;
    logic       trail_bit_q, trail_bit_d;
    logic [1:0] lp_q, lp_d;
    logic       hs_p_q, hs_p_d;
    logic       hs_n_q, hs_n_d;
    logic       ack_q, ack_d;
    logic       tmr_load_s;
    logic [7:0] tmr_val_s;
    logic       tmr_done_s;

    nano_dsi_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .done_o     (tmr_done_s)
    );

    // Packet sequencing, shift register and end-of-packet tracking
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        sh_d        = sh_q;
        bit_idx_d   = bit_idx_q;
        last_d      = last_q;
        trail_bit_d = trail_bit_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = 8'd0;
        case (state_q)
            DAT_IDLE: begin
                // A start in the same cycle as the strobe is honoured immediately
                if (pending_q || hs_start_i) begin
                    if (clk_sync_i) begin
                        state_d    = DAT_LPX;
                        pending_d  = 1'b0;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = phase_load(cfg_lpx_i);
                    end else begin
                        pending_d = 1'b1;
                    end
                end else begin
                    pending_d = pending_q;
                end
            end
            DAT_LPX: begin
                if (tmr_done_s) begin
                    state_d    = DAT_PREP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_hs_prep_i);
                end else begin
                    state_d = DAT_LPX;
                end
            end
            DAT_PREP: begin
                if (tmr_done_s) begin
                    state_d    = DAT_ZERO;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_hs_zero_i);
                end else begin
                    state_d = DAT_PREP;
                end
            end
            DAT_ZERO: begin
                if (tmr_done_s) begin
                    state_d = DAT_ALIGN;
                end else begin
                    state_d = DAT_ZERO;
                end
            end
            DAT_ALIGN: begin
                // The strobe marks the last bit of a clock byte; sync starts on the next one
                if (clk_sync_i) begin
                    state_d   = DAT_SYNC;
                    sh_d      = SYNC_BYTE;
                    bit_idx_d = 3'd0;
                    last_d    = 1'b0;
                end else begin
                    state_d = DAT_ALIGN;
                end
            end
            DAT_SYNC, DAT_PAYLOAD: begin
                if (bit_idx_q == 3'd7) begin
                    if ((state_q == DAT_SYNC) || !last_q) begin
                        state_d   = DAT_PAYLOAD;
                        sh_d      = hs_data_i;
                        last_d    = hs_last_i;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d     = DAT_TRAIL;
                        trail_bit_d = ~sh_q[0];
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = phase_load(cfg_hs_trail_i);
                    end
                end else begin
                    sh_d      = {1'b0, sh_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            DAT_TRAIL: begin
                if (tmr_done_s) begin
                    state_d    = DAT_EXIT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = phase_load(cfg_lpx_i);
                end else begin
                    state_d = DAT_TRAIL;
                end
            end
            DAT_EXIT: begin
                if (tmr_done_s) begin
                    state_d = DAT_IDLE;
                end else begin
                    state_d = DAT_EXIT;
                end
            end
            default: begin
                state_d = DAT_IDLE;
            end
        endcase
    end

    // Pin values and ack for the state being entered, so outputs are registered
    always_comb begin
        lp_d   = LP11;
        hs_p_d = 1'b0;
        hs_n_d = 1'b0;
        case (state_d)
            DAT_IDLE, DAT_EXIT: begin
                lp_d = LP11;
            end
            DAT_LPX: begin
                lp_d = LP01;
            end
            DAT_PREP: begin
                lp_d = LP00;
            end
            DAT_ZERO, DAT_ALIGN: begin
                lp_d   = LP00;
                hs_n_d = 1'b1;
            end
            DAT_SYNC, DAT_PAYLOAD: begin
                lp_d   = LP00;
                hs_p_d = sh_d[0];
                hs_n_d = ~sh_d[0];
            end
            DAT_TRAIL: begin
                lp_d   = LP00;
                hs_p_d = trail_bit_d;
                hs_n_d = ~trail_bit_d;
            end
            default: begin
                lp_d = LP11;
            end
        endcase
        // Ack rides on the last bit of every byte that is followed by another
        ack_d = (bit_idx_d == 3'd7) &&
                ((state_d == DAT_SYNC) || ((state_d == DAT_PAYLOAD) && !last_d));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DAT_IDLE;
            pending_q   <= 1'b0;
            sh_q        <= 8'd0;
            bit_idx_q   <= 3'd0;
            last_q      <= 1'b0;
            trail_bit_q <= 1'b0;
            lp_q        <= LP11;
            hs_p_q      <= 1'b0;
            hs_n_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            sh_q        <= sh_d;
            bit_idx_q   <= bit_idx_d;
            last_q      <= last_d;
            trail_bit_q <= trail_bit_d;
            lp_q        <= lp_d;
            hs_p_q      <= hs_p_d;
            hs_n_q      <= hs_n_d;
            ack_q       <= ack_d;
        end
    end

    assign lp_p_o   = lp_q[1];
    assign lp_n_o   = lp_q[0];
    assign hs_p_o   = hs_p_q;
    assign hs_n_o   = hs_n_q;
    assign hs_ack_o = ack_q;

endmodule

// File: rtl/nano_dsi_timer.sv
// Phase timer: 8-bit down-counter. Loading N-1 on the edge that enters a
// phase makes done_o rise in the N-th cycle of that phase.
module nano_dsi_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Load on request, otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/nano_dsi_phy_tx.sv
// Single-lane DSI D-PHY transmit front end: one clock lane and one data lane.
// The data lane is slaved to the clock lane's byte strobe only; it never
// waits on hs_clk_rdy. Build option NANO_DSI_CLK_CONT_EN selects a
// continuous HS clock.
module nano_dsi_phy_tx import nano_dsi_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_lpx,
    input  logic [7:0] cfg_hs_prep,
    input  logic [7:0] cfg_hs_zero,
    input  logic [7:0] cfg_hs_trail,
    input  logic       hs_clk_req,
    output logic       hs_clk_rdy,
    input  logic       hs_start,
    input  logic [7:0] hs_data,
    input  logic       hs_last,
    output logic       hs_ack,
    output logic       clk_lp_p,
    output logic       clk_lp_n,
    output logic       clk_hs_p,
    output logic       clk_hs_n,
    output logic       data_lp_p,
    output logic       data_lp_n,
    output logic       data_hs_p,
    output logic       data_hs_n
);

    logic clk_sync_s;

    nano_dsi_clk u_clk (
        .clk            (clk),
        .rst            (rst),
        .cfg_lpx_i      (cfg_lpx),
        .cfg_hs_prep_i  (cfg_hs_prep),
        .cfg_hs_zero_i  (cfg_hs_zero),
        .cfg_hs_trail_i (cfg_hs_trail),
        .hs_clk_req_i   (hs_clk_req),
        .hs_clk_rdy_o   (hs_clk_rdy),
        .clk_sync_o     (clk_sync_s),
        .lp_p_o         (clk_lp_p),
        .lp_n_o         (clk_lp_n),
        .hs_p_o         (clk_hs_p),
        .hs_n_o         (clk_hs_n)
    );

    nano_dsi_data u_data (
        .clk            (clk),
        .rst            (rst),
        .cfg_lpx_i      (cfg_lpx),
        .cfg_hs_prep_i  (cfg_hs_prep),
        .cfg_hs_zero_i  (cfg_hs_zero),
        .cfg_hs_trail_i (cfg_hs_trail),
        .clk_sync_i     (clk_sync_s),
        .hs_start_i     (hs_start),
        .hs_data_i      (hs_data),
        .hs_last_i      (hs_last),
        .hs_ack_o       (hs_ack),
        .lp_p_o         (data_lp_p),
        .lp_n_o         (data_lp_n),
        .hs_p_o         (data_hs_p),
        .hs_n_o         (data_hs_n)
    );

endmodule

// File: tb/tb_nano_dsi_phy_tx.sv
// Directed bench for nano_dsi_phy_tx (default build, non-continuous clock).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_nano_dsi_phy_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_trail;
    logic       hs_clk_req, hs_clk_rdy;
    logic       hs_start, hs_last, hs_ack;
    logic [7:0] hs_data;
    logic       clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n;
    logic       data_lp_p, data_lp_n, data_hs_p, data_hs_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes [18];
    int         src_idx;
    int         acks;
    int         n;
    logic       b;
    logic       exp_ack;
    logic       got_ack;

    always #5 clk = ~clk;

    nano_dsi_phy_tx dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_lpx      (cfg_lpx),
        .cfg_hs_prep  (cfg_hs_prep),
        .cfg_hs_zero  (cfg_hs_zero),
        .cfg_hs_trail (cfg_hs_trail),
        .hs_clk_req   (hs_clk_req),
        .hs_clk_rdy   (hs_clk_rdy),
        .hs_start     (hs_start),
        .hs_data      (hs_data),
        .hs_last      (hs_last),
        .hs_ack       (hs_ack),
        .clk_lp_p     (clk_lp_p),
        .clk_lp_n     (clk_lp_n),
        .clk_hs_p     (clk_hs_p),
        .clk_hs_n     (clk_hs_n),
        .data_lp_p    (data_lp_p),
        .data_lp_n    (data_lp_n),
        .data_hs_p    (data_hs_p),
        .data_hs_n    (data_hs_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source side: after an ack has been consumed, present the next byte
    task automatic advance_source();
        acks++;
        src_idx++;
        if (src_idx < 18) begin
            hs_data = exp_bytes[src_idx];
            hs_last = (src_idx == 17);
        end else begin
            hs_data = 8'h00;
            hs_last = 1'b0;
        end
    endtask

    initial begin
        exp_bytes[0] = 8'hB8;
        exp_bytes[1] = 8'h0F;
        for (int j = 2; j < 18; j++) exp_bytes[j] = 8'h10 + 8'(j - 2);

        rst = 1'b1; cfg_lpx = 8'd0; cfg_hs_prep = 8'd0; cfg_hs_zero = 8'd0; cfg_hs_trail = 8'd0;
        hs_clk_req = 1'b0; hs_start = 1'b0; hs_data = 8'h00; hs_last = 1'b0;

        // ---- Reset ----
        repeat (10) step();
        chk("rst_clk_pins", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n}), 32'h0000000C);
        chk("rst_dat_pins", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n}), 32'h0000000C);
        chk("rst_flags", 32'({hs_clk_rdy, hs_ack, dut.clk_sync_s}), 32'h0);

        cfg_lpx = 8'd4; cfg_hs_prep = 8'd16; cfg_hs_zero = 8'd16; cfg_hs_trail = 8'd16;
        rst = 1'b0;
        step();
        chk("idle_clk", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h18);

        // ---- Clock entry ----
        hs_clk_req = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("clk_lpx", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h08);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("clk_prep", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h00);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("clk_zero", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h02);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            b = ((i % 2) == 0);
            chk("clk_run", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy, dut.clk_sync_s}),
                32'({2'b00, b, ~b, 1'b1, ((i % 8) == 7)}));
            step();
        end

        // ---- Packet ----
        src_idx = 1; acks = 0;
        hs_data = exp_bytes[1]; hs_last = 1'b0; hs_start = 1'b1;
        step();
        hs_start = 1'b0;
        n = 1;
        while (({data_lp_p, data_lp_n} != 2'b01) && (n < 12)) begin
            step();
            n++;
        end
        chk("start_latency_in_1_8", 32'((n >= 1) && (n <= 8)), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("dat_lpx", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h08);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("dat_prep", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h00);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("dat_zero", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h02);
            if (i == 4) hs_start = 1'b1;
            if (i == 5) hs_start = 1'b0;
            step();
        end
        // LPX begins on a clock-byte boundary, so 36 entry cycles end 4 bits before the next one
        for (int i = 0; i < 4; i++) begin
            chk("dat_align", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h02);
            step();
        end
        for (int k = 0; k < 144; k++) begin
            b       = exp_bytes[k / 8][k % 8];
            exp_ack = ((k % 8) == 7) && ((k / 8) < 17);
            chk("stream", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}),
                32'({2'b00, b, ~b, exp_ack}));
            got_ack = hs_ack;
            step();
            if (got_ack) advance_source();
        end
        chk("ack_count", 32'(acks), 32'd17);
        for (int i = 0; i < 16; i++) begin
            chk("dat_trail", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h04);
            step();
        end
        // EXIT then IDLE; the start pulsed during ZERO must not launch a second packet
        for (int i = 0; i < 40; i++) begin
            chk("dat_lp11_after", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h18);
            step();
        end

        // ---- Clock exit ----
        n = 0;
        while ((dut.clk_sync_s !== 1'b1) && (n < 16)) begin
            step();
            n++;
        end
        chk("sync_found", 32'(n < 16), 32'h1);
        step(); step(); step();          // counter now 2
        hs_clk_req = 1'b0;
        step();                          // counter 3
        hs_clk_req = 1'b1;
        for (int i = 3; i < 8; i++) begin
            chk("run_tail", 32'({clk_lp_p, clk_lp_n, hs_clk_rdy, dut.clk_sync_s}), 32'({3'b001, (i == 7)}));
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("clk_trail", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h02);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("clk_exit", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h18);
            step();
        end
        n = 0;
        while (({clk_lp_p, clk_lp_n} != 2'b01) && (n < 3)) begin
            step();
            n++;
        end
        chk("clk_reentry_lp01", 32'({clk_lp_p, clk_lp_n}), 32'h1);
        repeat (35) step();
        chk("reentry_not_yet_rdy", 32'(hs_clk_rdy), 32'h0);
        step();
        chk("reentry_rdy", 32'(hs_clk_rdy), 32'h1);

        // ---- Reset mid-packet ----
        src_idx = 1; acks = 0;
        hs_data = exp_bytes[1]; hs_last = 1'b0; hs_start = 1'b1;
        step();
        hs_start = 1'b0;
        n = 0;
        while ((acks < 3) && (n < 200)) begin
            got_ack = hs_ack;
            step();
            n++;
            if (got_ack) advance_source();
        end
        chk("pre_rst_acks", 32'(acks), 32'd3);
        rst = 1'b1;
        step();
        chk("rst_mid_clk", 32'({clk_lp_p, clk_lp_n, clk_hs_p, clk_hs_n, hs_clk_rdy}), 32'h18);
        chk("rst_mid_dat", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h18);
        rst = 1'b0;
        hs_clk_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk("post_rst_quiet", 32'({data_lp_p, data_lp_n, data_hs_p, data_hs_n, hs_ack}), 32'h18);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
